// File: rtl/lpf_ctrl_pkg.sv
// rtl/lpf_ctrl_pkg.sv - shared types, defaults and helpers for the LPF coefficient sequencer
package lpf_ctrl_pkg;

   localparam int LPF_NTAPS      = 8;
   localparam int LPF_COEFF_BITS = 18;

   // Slot 7 occupies the MSBs, slot 0 the LSBs.
   localparam logic [LPF_NTAPS*LPF_COEFF_BITS-1:0] LPF_DEFAULT_COEFFS = {
      18'sd10342, -18'sd3216, 18'sd1672, -18'sd949,
      18'sd526,   -18'sd263,  18'sd105,  -18'sd23
   };

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_COPY   = 2'd1,
      ST_STROBE = 2'd2,
      ST_FLUSH  = 2'd3
   } lpf_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + 4'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - saturating counter of saturated lane-samples, clear has priority
module sat_event_counter
   import lpf_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        clr_i,
   input  logic [7:0]  flags_i,
   output logic [15:0] count_o
);

   logic [15:0] r_count;
   logic [3:0]  w_inc;
   logic [16:0] w_sum;

   assign w_inc   = popcount8(flags_i);
   assign w_sum   = {1'b0, r_count} + 17'(w_inc);
   assign count_o = r_count;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_count <= 16'd0;
      end else if (en_i) begin
         r_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
   end

endmodule

// File: rtl/lpf_coeff_sequencer.sv
// rtl/lpf_coeff_sequencer.sv - double-banked coefficient loader with flush masking and saturation stats
module lpf_coeff_sequencer
   import lpf_ctrl_pkg::*;
#(
   parameter int NTAPS        = LPF_NTAPS,
   parameter int COEFF_BITS   = LPF_COEFF_BITS,
   parameter int FLUSH_CYCLES = 12,
   parameter logic [NTAPS*COEFF_BITS-1:0] DEFAULT_COEFFS = LPF_DEFAULT_COEFFS
)
(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          coeff_wr_i,
   input  logic [2:0]                    coeff_addr_i,
   input  logic [COEFF_BITS-1:0]         coeff_dat_i,
   input  logic                          commit_i,
   input  logic [7:0]                    sat_i,
   input  logic                          sat_clr_i,
   output logic [NTAPS*COEFF_BITS-1:0]   coeff_o,
   output logic                          coeff_ce_o,
   output logic                          filt_rst_o,
   output logic                          busy_o,
   output logic                          dat_valid_o,
   output logic [15:0]                   sat_count_o
);

   localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

   lpf_state_t                    r_state;
   lpf_state_t                    w_next_state;
   logic [7:0]                    r_flush_cnt;
   logic                          r_pending;
   logic [NTAPS*COEFF_BITS-1:0]   r_shadow;
   logic [NTAPS*COEFF_BITS-1:0]   r_active;
   logic                          r_coeff_ce;
   logic                          r_filt_rst;
   logic                          r_busy;
   logic                          r_dat_valid;
   logic                          w_coeff_ce_nxt;
   logic                          w_filt_rst_nxt;
   logic                          w_dat_valid_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_COPY;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_RUN:    if (commit_i || r_pending) w_next_state = ST_COPY;
         ST_COPY:   w_next_state = ST_STROBE;
         ST_STROBE: w_next_state = ST_FLUSH;
         ST_FLUSH:  if (r_flush_cnt == 8'd0) w_next_state = ST_RUN;
         default:   w_next_state = ST_COPY;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with r_state.
   always_comb begin
      w_filt_rst_nxt  = (w_next_state == ST_COPY);
      w_coeff_ce_nxt  = (w_next_state == ST_STROBE);
      w_dat_valid_nxt = (w_next_state == ST_RUN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_filt_rst  <= 1'b1;
         r_coeff_ce  <= 1'b0;
         r_dat_valid <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_filt_rst  <= w_filt_rst_nxt;
         r_coeff_ce  <= w_coeff_ce_nxt;
         r_dat_valid <= w_dat_valid_nxt;
         r_busy      <= !w_dat_valid_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_flush_cnt <= 8'd0;
      end else if (r_state == ST_STROBE) begin
         r_flush_cnt <= FLUSH_LOAD;
      end else if (r_state == ST_FLUSH && r_flush_cnt != 8'd0) begin
         r_flush_cnt <= r_flush_cnt - 8'd1;
      end
   end

   // A RUN cycle always consumes the pending request, so commits while busy collapse to one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pending <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_pending <= 1'b0;
      end else if (commit_i) begin
         r_pending <= 1'b1;
      end
   end

   // Active copies the pre-write shadow in COPY; a same-cycle write lands for the next commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_shadow <= DEFAULT_COEFFS;
         r_active <= DEFAULT_COEFFS;
      end else begin
         if (coeff_wr_i) begin
            r_shadow[int'(coeff_addr_i)*COEFF_BITS +: COEFF_BITS] <= coeff_dat_i;
         end
         if (r_state == ST_COPY) begin
            r_active <= r_shadow;
         end
      end
   end

   sat_event_counter u_sat_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (r_dat_valid),
      .clr_i   (sat_clr_i),
      .flags_i (sat_i),
      .count_o (sat_count_o)
   );

   assign coeff_o     = r_active;
   assign coeff_ce_o  = r_coeff_ce;
   assign filt_rst_o  = r_filt_rst;
   assign busy_o      = r_busy;
   assign dat_valid_o = r_dat_valid;

endmodule

// File: tb/tb_lpf_coeff_sequencer.sv
// tb/tb_lpf_coeff_sequencer.sv - scoreboard bench for lpf_coeff_sequencer
module tb_lpf_coeff_sequencer;

   localparam logic [143:0] DEF = {
      18'sd10342, -18'sd3216, 18'sd1672, -18'sd949,
      18'sd526,   -18'sd263,  18'sd105,  -18'sd23
   };

   typedef struct {
      logic [143:0] bank;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         coeff_wr_i;
   logic [2:0]   coeff_addr_i;
   logic [17:0]  coeff_dat_i;
   logic         commit_i;
   logic [7:0]   sat_i;
   logic         sat_clr_i;
   logic [143:0] coeff_o;
   logic         coeff_ce_o;
   logic         filt_rst_o;
   logic         busy_o;
   logic         dat_valid_o;
   logic [15:0]  sat_count_o;

   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   exp_t         sb[$];
   logic [143:0] exp_shadow;

   lpf_coeff_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .coeff_wr_i   (coeff_wr_i),
      .coeff_addr_i (coeff_addr_i),
      .coeff_dat_i  (coeff_dat_i),
      .commit_i     (commit_i),
      .sat_i        (sat_i),
      .sat_clr_i    (sat_clr_i),
      .coeff_o      (coeff_o),
      .coeff_ce_o   (coeff_ce_o),
      .filt_rst_o   (filt_rst_o),
      .busy_o       (busy_o),
      .dat_valid_o  (dat_valid_o),
      .sat_count_o  (sat_count_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [143:0] bank, input int at);
      exp_t e;
      e.bank = bank;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   task automatic set_slot(input int k, input logic [17:0] v);
      exp_shadow[k*18 +: 18] = v;
   endtask

   // Monitor: every coeff_ce_o pulse must match the oldest expected load, bank and cycle.
   always @(negedge clk) begin
      if (coeff_ce_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe cyc=%0d got=1 want=0", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_bank", coeff_o, e.bank);
            chk("strobe_cycle", 144'(cyc), 144'(e.cyc));
         end
      end
   end

   initial begin
      int n;
      int r0;
      rst_i = 1'b1; coeff_wr_i = 1'b0; coeff_addr_i = 3'd0; coeff_dat_i = 18'd0;
      commit_i = 1'b0; sat_i = 8'd0; sat_clr_i = 1'b0;
      exp_shadow = DEF;
      tick(3);
      chk("rst_filt_rst", filt_rst_o, 1);
      chk("rst_coeff_ce", coeff_ce_o, 0);
      chk("rst_valid", dat_valid_o, 0);
      chk("rst_busy", busy_o, 1);
      chk("rst_sat", sat_count_o, 0);
      chk("rst_coeff", coeff_o, DEF);

      // Reset release: COPY at c0, strobe c1, valid from c14
      rst_i = 1'b0; r0 = cyc; push(DEF, r0 + 1);
      tick(13);
      chk("rel_valid_c13", dat_valid_o, 0);
      tick(1);
      chk("rel_valid_c14", dat_valid_o, 1);
      chk("rel_busy_c14", busy_o, 0);
      chk("rel_filt_rst_c14", filt_rst_o, 0);
      tick(2);

      // Write slot3=700, commit next cycle
      coeff_wr_i = 1'b1; coeff_addr_i = 3'd3; coeff_dat_i = 18'd700; set_slot(3, 18'd700);
      tick(1);
      coeff_wr_i = 1'b0;
      n = cyc; commit_i = 1'b1; push(exp_shadow, n + 2);
      tick(1);
      commit_i = 1'b0;
      chk("c1_filt_rst", filt_rst_o, 1);
      chk("c1_busy", busy_o, 1);
      tick(13);
      chk("c1_busy_n14", busy_o, 1);
      tick(1);
      chk("c1_busy_n15", busy_o, 0);
      tick(2);

      // Write slot5=-5 with commit; write in COPY goes to next bank
      n = cyc;
      coeff_wr_i = 1'b1; coeff_addr_i = 3'd5; coeff_dat_i = -18'sd5; commit_i = 1'b1;
      set_slot(5, -18'sd5); push(exp_shadow, n + 2);
      tick(1);
      commit_i = 1'b0; coeff_addr_i = 3'd1; coeff_dat_i = 18'd77; set_slot(1, 18'd77);
      tick(1);
      coeff_wr_i = 1'b0;
      tick(13);
      chk("c2_valid_n15", dat_valid_o, 1);
      tick(2);

      // Three commits during FLUSH merge into one extra sequence
      n = cyc; commit_i = 1'b1; push(exp_shadow, n + 2);
      tick(1);
      commit_i = 1'b0;
      tick(3);
      commit_i = 1'b1;
      tick(1);
      commit_i = 1'b0;
      coeff_wr_i = 1'b1; coeff_addr_i = 3'd0; coeff_dat_i = 18'd123; set_slot(0, 18'd123);
      tick(1);
      coeff_wr_i = 1'b0; commit_i = 1'b1;
      tick(1);
      commit_i = 1'b0;
      tick(1);
      commit_i = 1'b1;
      tick(1);
      commit_i = 1'b0;
      push(exp_shadow, n + 17);
      tick(6);
      chk("pend_valid_n15", dat_valid_o, 1);
      tick(1);
      chk("pend_valid_n16", dat_valid_o, 0);
      chk("pend_filt_rst_n16", filt_rst_o, 1);
      tick(13);
      chk("pend_valid_n29", dat_valid_o, 0);
      tick(1);
      chk("pend_valid_n30", dat_valid_o, 1);
      tick(5);
      chk("pend_valid_n35", dat_valid_o, 1);

      // Saturation counter
      chk("sat_zero", sat_count_o, 0);
      sat_i = 8'hA5;
      tick(3);
      sat_i = 8'h00;
      chk("sat_a5x3", sat_count_o, 12);
      sat_clr_i = 1'b1; sat_i = 8'h0F;
      tick(1);
      sat_clr_i = 1'b0; sat_i = 8'h00;
      chk("sat_clr1", sat_count_o, 0);
      n = cyc; commit_i = 1'b1; push(exp_shadow, n + 2);
      tick(1);
      commit_i = 1'b0; sat_i = 8'hFF;
      tick(14);
      sat_i = 8'h00;
      chk("sat_busy_nocount", sat_count_o, 0);
      sat_i = 8'hFF;
      tick(8191);
      chk("sat_8191", sat_count_o, 65528);
      tick(1);
      chk("sat_full", sat_count_o, 16'hFFFF);
      tick(8);
      chk("sat_hold", sat_count_o, 16'hFFFF);
      sat_clr_i = 1'b1; sat_i = 8'h0F;
      tick(1);
      sat_clr_i = 1'b0; sat_i = 8'h00;
      chk("sat_clr2", sat_count_o, 0);

      // Reset mid-FLUSH after shadow edit and pending commit
      n = cyc; commit_i = 1'b1; push(exp_shadow, n + 2);
      tick(1);
      commit_i = 1'b0;
      tick(4);
      coeff_wr_i = 1'b1; coeff_addr_i = 3'd2; coeff_dat_i = 18'd999;
      tick(1);
      coeff_wr_i = 1'b0; commit_i = 1'b1;
      tick(1);
      commit_i = 1'b0;
      tick(1);
      rst_i = 1'b1;
      tick(2);
      chk("rst2_coeff", coeff_o, DEF);
      chk("rst2_filt_rst", filt_rst_o, 1);
      chk("rst2_busy", busy_o, 1);
      chk("rst2_valid", dat_valid_o, 0);
      rst_i = 1'b0; r0 = cyc; exp_shadow = DEF; push(DEF, r0 + 1);
      tick(14);
      chk("rst2_valid_c14", dat_valid_o, 1);
      tick(1);
      chk("rst2_no_pending", dat_valid_o, 1);
      tick(10);
      chk("sb_drained", 144'(sb.size()), 144'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lpf_coeff_sequencer.md
LPF_COEFF_SEQUENCER -- requirements
Module: lpf_coeff_sequencer

Interface
REQ-001 Parameter NTAPS, default 8, number of coefficient slots driven to the filter.
REQ-002 Parameter COEFF_BITS, default 18, coefficient width (DSP B-port width).
REQ-003 Parameter FLUSH_CYCLES, default 12, filter pipeline depth to mask after a coefficient change; legal range 1..255.
REQ-004 Parameter DEFAULT_COEFFS, default {10342,-3216,1672,-949,526,-263,105,-23} (slot 7..0), reset contents of both banks.
REQ-005 clk_i  in  1  single clock; reset is synchronous and active-high on rst_i.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 coeff_wr_i  in  1  write strobe to shadow bank.
REQ-008 coeff_addr_i  in  3  shadow slot index.
REQ-009 coeff_dat_i  in  COEFF_BITS  signed coefficient to write.
REQ-010 commit_i  in  1  request to swap the shadow bank into the active bank.
REQ-011 sat_i  in  8  per-lane saturation flags from the filter output stage.
REQ-012 sat_clr_i  in  1  clear saturation counter.
REQ-013 coeff_o  out  NTAPS*COEFF_BITS  active bank, slot k at bits [k*COEFF_BITS +: COEFF_BITS].
REQ-014 coeff_ce_o  out  1  one-cycle load enable for the filter coefficient registers.
REQ-015 filt_rst_o  out  1  reset to the filter datapath.
REQ-016 busy_o  out  1  high whenever state is not RUN.
REQ-017 dat_valid_o  out  1  filter output qualifies as valid.
REQ-018 sat_count_o  out  16  saturating count of saturated lane-samples.

Function
REQ-019 States SHALL be RUN, COPY, STROBE, FLUSH; all outputs registered.
REQ-020 coeff_wr_i SHALL write coeff_dat_i into shadow[coeff_addr_i] in every state; the active bank is never written directly.
REQ-021 RUN + commit_i (cycle N) SHALL go to COPY at N+1; COPY copies shadow to active and asserts filt_rst_o; STROBE at N+2 asserts coeff_ce_o with new coeff_o stable; FLUSH from N+3 for FLUSH_CYCLES cycles; RUN at N+3+FLUSH_CYCLES.
REQ-022 dat_valid_o SHALL be 1 only in RUN; busy_o = !dat_valid_o.
REQ-023 Write and commit in the same cycle SHALL include that write in the copied bank (write precedes snapshot).
REQ-024 commit_i while busy SHALL set a single pending flag; further commits while pending merge; on entering RUN with pending set, the FSM SHALL proceed to COPY next cycle and clear the flag (dat_valid_o high for exactly that one RUN cycle).
REQ-025 Writes during COPY SHALL not affect the bank being copied that cycle; they land in shadow for the next commit.
REQ-026 When dat_valid_o=1, sat_count_o SHALL add popcount(sat_i) (0..8), saturating at 16'hFFFF, never wrapping.
REQ-027 sat_clr_i SHALL zero sat_count_o next cycle and SHALL win over a simultaneous increment.
REQ-028 FLUSH counter SHALL be 8 bits, load FLUSH_CYCLES-1, exit on zero.

Reset
REQ-029 rst_i SHALL load both banks with DEFAULT_COEFFS, clear pending, zero sat_count_o, drive filt_rst_o=1, coeff_ce_o=0, dat_valid_o=0, busy_o=1, state=COPY.
REQ-030 After rst_i deasserts the FSM SHALL run COPY, STROBE, FLUSH, RUN automatically; reset mid-sequence aborts it, discards pending commit and shadow edits.

Structure
REQ-031 Package lpf_ctrl_pkg SHALL hold the state enum, NTAPS/COEFF_BITS defaults and DEFAULT_COEFFS.
REQ-032 Saturation counter SHALL be sub-module sat_event_counter (popcount, saturating add, clear priority).

Verification
REQ-033 Reset release: rst_i low at cycle 0 -> COPY c0, coeff_ce_o=1 c1 with coeff_o slot0=-23, dat_valid_o=1 from c14 (FLUSH_CYCLES=12).
REQ-034 Write slot3=700 then commit in RUN at N -> coeff_o slot3=700 and coeff_ce_o=1 at N+2, busy_o low at N+15.
REQ-035 Write slot5=-5 and commit same cycle -> copied bank has slot5=-5.
REQ-036 Three commits during FLUSH -> exactly one extra COPY/STROBE/FLUSH sequence, one coeff_ce_o pulse.
REQ-037 sat_i=8'hFF for 8200 valid cycles -> sat_count_o=16'hFFFF, held; sat_clr_i with sat_i=8'h0F -> 0.
REQ-038 rst_i asserted mid-FLUSH after shadow edit -> coeff_o returns to DEFAULT_COEFFS, pending cleared.
